// File: rtl/wr_req_responder_if.sv
// Crossbar write-request channel plus slave write bus for one wr_req_responder slave port.
// The master modport is the environment side (crossbar and slave); the slave modport is the responder.
interface wr_req_responder_if #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 req_in;
    logic [AWIDTH-1:0]    addr_in;
    logic [DWIDTH-1:0]    wdata_in;
    logic                 ack_out;
    logic                 slv_we;
    logic [AWIDTH-2:0]    slv_addr;
    logic [DWIDTH-1:0]    slv_wdata;
    logic                 slv_ready;
    logic                 busy;
    logic                 err;
    logic [CNT_WIDTH-1:0] wr_count;

    modport master (
        output req_in, addr_in, wdata_in, slv_ready,
        input  ack_out, slv_we, slv_addr, slv_wdata, busy, err, wr_count
    );

    modport slave (
        input  req_in, addr_in, wdata_in, slv_ready,
        output ack_out, slv_we, slv_addr, slv_wdata, busy, err, wr_count
    );
endinterface

// File: rtl/wr_req_responder.sv
// Turns one held crossbar write request into a single slave write and a 1-cycle ack (min 2 edges req->ack).
// Holds slv_we until slv_ready; optional slave-ready timeout under WR_REQ_RESPONDER_TIMEOUT_EN.
module wr_req_responder #(
    parameter int AWIDTH         = 32,
    parameter int DWIDTH         = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               aclk,
    input logic               aresetn,
    wr_req_responder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ_HIGH,
        WRITE,
        ACK,
        WAIT_REQ_LOW
    } state_t;

    state_t state;

    // The slave-select bit was already consumed by the crossbar routing.
    logic unused_sel;

`ifdef WR_REQ_RESPONDER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    assign unused_sel = bus.addr_in[AWIDTH-1];
`else
    assign unused_sel = bus.addr_in[AWIDTH-1] ^ (TIMEOUT_CYCLES == 0);
    assign bus.err    = 1'b0;
`endif

    assign bus.busy = (state != IDLE) && (state != WAIT_REQ_HIGH);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            bus.ack_out   <= 1'b0;
            bus.slv_we    <= 1'b0;
            bus.slv_addr  <= '0;
            bus.slv_wdata <= '0;
            bus.wr_count  <= '0;
`ifdef WR_REQ_RESPONDER_TIMEOUT_EN
            bus.err       <= 1'b0;
            to_cnt        <= '0;
`endif
        end else begin
            bus.ack_out <= 1'b0;
`ifdef WR_REQ_RESPONDER_TIMEOUT_EN
            bus.err     <= 1'b0;
`endif
            case (state)
                IDLE: state <= WAIT_REQ_HIGH;

                WAIT_REQ_HIGH: begin
                    if (bus.req_in) begin
                        bus.slv_addr  <= bus.addr_in[AWIDTH-2:0];
                        bus.slv_wdata <= bus.wdata_in;
                        bus.slv_we    <= 1'b1;
                        state         <= WRITE;
`ifdef WR_REQ_RESPONDER_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end
                end

                // A dropped req does not cancel: the slave write is already committed.
                WRITE: begin
                    if (bus.slv_ready && bus.slv_we) begin
                        bus.slv_we   <= 1'b0;
                        bus.ack_out  <= 1'b1;
                        bus.wr_count <= bus.wr_count + CNT_WIDTH'(1);
                        state        <= ACK;
                    end
`ifdef WR_REQ_RESPONDER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        bus.slv_we  <= 1'b0;
                        bus.ack_out <= 1'b1;
                        bus.err     <= 1'b1;
                        state       <= ACK;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end

                ACK: state <= bus.req_in ? WAIT_REQ_LOW : WAIT_REQ_HIGH;

                // A still-high req is the request just served, never a new one.
                WAIT_REQ_LOW: begin
                    if (!bus.req_in) state <= WAIT_REQ_HIGH;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wr_req_responder.sv
// Randomized transaction-level bench for wr_req_responder against a per-request timing model.
module tb_wr_req_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 4;
`ifdef WR_REQ_RESPONDER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    wr_req_responder_if #(.AWIDTH(AW), .DWIDTH(DW), .CNT_WIDTH(CW)) bus ();

    wr_req_responder #(
        .AWIDTH(AW), .DWIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    always #5 aclk = ~aclk;

    int n_chk   = 0;
    int n_pass  = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input bit exp_busy);
        check({tag, "_we"},   bus.slv_we,  0);
        check({tag, "_ack"},  bus.ack_out, 0);
        check({tag, "_busy"}, bus.busy,    64'(exp_busy));
        check({tag, "_err"},  bus.err,     0);
    endtask

    // One request: accepted on the next edge, slave ready after 'delay' stalled WRITE cycles,
    // req held 'hold' cycles past the ack (or dropped mid-write when 'cancel').
    task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int delay, input int hold, input bit cancel);
        logic [AW-2:0] ea;
        bit tmo;
        int lim;
        int h;
        ea  = a[AW-2:0];
        tmo = TO_EN && (delay >= TO);
        lim = tmo ? TO - 1 : delay;
        h   = cancel ? 0 : hold;

        bus.req_in    = 1'b1;
        bus.addr_in   = a;
        bus.wdata_in  = d;
        bus.slv_ready = 1'($urandom_range(0, 1));
        tick();
        check("acc_we",    bus.slv_we,    1);
        check("acc_addr",  bus.slv_addr,  64'(ea));
        check("acc_wdata", bus.slv_wdata, 64'(d));
        check("acc_ack",   bus.ack_out,   0);
        check("acc_busy",  bus.busy,      1);

        if (cancel) bus.req_in = 1'b0;
        bus.slv_ready = (delay == 0);
        bus.addr_in   = $urandom;
        bus.wdata_in  = $urandom;
        for (int i = 1; i <= lim; i++) begin
            tick();
            check("wr_we",    bus.slv_we,    1);
            check("wr_addr",  bus.slv_addr,  64'(ea));
            check("wr_wdata", bus.slv_wdata, 64'(d));
            check("wr_ack",   bus.ack_out,   0);
            bus.addr_in  = $urandom;
            bus.wdata_in = $urandom;
            if (i == delay) bus.slv_ready = 1'b1;
        end

        tick();
        if (!tmo) exp_cnt++;
        check("done_ack",   bus.ack_out,  1);
        check("done_we",    bus.slv_we,   0);
        check("done_err",   bus.err,      64'(tmo));
        check("done_busy",  bus.busy,     1);
        check("done_count", bus.wr_count, 64'(exp_cnt % (1 << CW)));

        bus.slv_ready = 1'($urandom_range(0, 1));
        for (int k = 0; k < h; k++) begin
            tick();
            check_quiet("hold", 1'b1);
        end
        bus.req_in = 1'b0;
        tick();
        check_quiet("rel", 1'b0);
    endtask

    initial begin
        bus.req_in    = 1'b0;
        bus.addr_in   = '0;
        bus.wdata_in  = '0;
        bus.slv_ready = 1'b0;
        repeat (3) tick();
        check_quiet("rst", 1'b0);
        check("rst_count", bus.wr_count,  0);
        check("rst_addr",  bus.slv_addr,  0);
        check("rst_wdata", bus.slv_wdata, 0);
        aresetn = 1'b1;
        tick();
        check_quiet("idle", 1'b0);

        do_txn(32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 1'b0);
        do_txn(32'h8000_0abc, 32'h1234_5678, 5, 0, 1'b0);
        do_txn(32'h0000_0040, 32'hCAFE_F00D, 1, 4, 1'b0);
        do_txn(32'h0000_0044, 32'h0000_0001, 0, 0, 1'b0);
        do_txn(32'h8000_0100, 32'h5555_AAAA, 2, 0, 1'b1);
        do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, TO - 1, 1, 1'b0);
        do_txn(32'h7FFF_FFFC, 32'h0F0F_0F0F, TO + 2, 2, 1'b0);

        for (int t = 0; t < 30; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.slv_ready = 1'($urandom_range(0, 1));
                tick();
                check_quiet("gap", 1'b0);
            end
            do_txn($urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 3),
                   ($urandom_range(0, 4) == 0));
        end

        // Reset while the slave is stalled: the write is dropped and never acknowledged.
        bus.req_in    = 1'b1;
        bus.addr_in   = 32'h8000_0020;
        bus.wdata_in  = 32'hBAD0_BAD0;
        bus.slv_ready = 1'b0;
        tick();
        check("mid_we", bus.slv_we, 1);
        tick();
        tick();
        aresetn = 1'b0;
        tick();
        exp_cnt = 0;
        check_quiet("mid_rst", 1'b0);
        check("mid_rst_count", bus.wr_count, 0);
        bus.req_in    = 1'b0;
        bus.slv_ready = 1'b1;
        tick();
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_quiet("post_rst", 1'b0);
        end

        do_txn(32'h8000_0030, 32'h0BAD_CAFE, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
